// File: rtl/snake_pkg.sv
// Shared widths, screen limits, colours and requester encoding for the snake game.
package snake_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int C_W   = 3;
   localparam int X_MAX = 159;
   localparam int Y_MAX = 119;

   localparam logic [2:0] BG_COLOUR   = 3'b000;
   localparam logic [2:0] FOOD_COLOUR = 3'b100;

   typedef enum logic [1:0] {
      REQ_HEAD = 2'd0,
      REQ_TAIL = 2'd1,
      REQ_FOOD = 2'd2
   } req_idx_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } plot_state_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: the most recently granted requester drops to lowest priority.
module rr_arbiter3
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [2:0] req,
   input  logic       en,
   output logic [2:0] grant
);

   req_idx_e last_q;

   always_comb begin
      grant = 3'b000;
      case (last_q)
         REQ_HEAD: begin
            if      (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
         end
         REQ_TAIL: begin
            if      (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
         end
         default: begin
            if      (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
         end
      endcase
   end

   // Starting from "food was last" makes the post-reset order head > tail > food.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= REQ_FOOD;
      end else if (en && (grant != 3'b000)) begin
         if (grant[0])      last_q <= REQ_HEAD;
         else if (grant[1]) last_q <= REQ_TAIL;
         else               last_q <= REQ_FOOD;
      end
   end

endmodule

// File: rtl/plot_arbiter.sv
// Owns the VGA pixel-write port: sweeps the frame to background, then shares the port
// between head draw, tail erase and food draw with a round-robin req/ack handshake.
module plot_arbiter
   import snake_pkg::*;
#(
   parameter int X_W = snake_pkg::X_W,
   parameter int Y_W = snake_pkg::Y_W,
   parameter int C_W = snake_pkg::C_W,
   parameter int X_MAX = snake_pkg::X_MAX,
   parameter int Y_MAX = snake_pkg::Y_MAX,
   parameter logic [C_W-1:0] BG_COLOUR = snake_pkg::BG_COLOUR
)(
   input  logic           clk,
   input  logic           resetn,
   input  logic           clear_req,
   output logic           busy,
   output logic           oob_err,
   input  logic           head_req,
   input  logic [X_W-1:0] head_x,
   input  logic [Y_W-1:0] head_y,
   input  logic [C_W-1:0] head_colour,
   output logic           head_ack,
   input  logic           tail_req,
   input  logic [X_W-1:0] tail_x,
   input  logic [Y_W-1:0] tail_y,
   output logic           tail_ack,
   input  logic           food_req,
   input  logic [X_W-1:0] food_x,
   input  logic [Y_W-1:0] food_y,
   input  logic [C_W-1:0] food_colour,
   output logic           food_ack,
   output logic [X_W-1:0] vga_x,
   output logic [Y_W-1:0] vga_y,
   output logic [C_W-1:0] vga_colour,
   output logic           vga_plot
);

   localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

   plot_state_e    state_q, state_d;
   logic [X_W-1:0] cx_q, cx_d;
   logic [Y_W-1:0] cy_q, cy_d;
   logic [X_W-1:0] x_d;
   logic [Y_W-1:0] y_d;
   logic [C_W-1:0] colour_d;
   logic           plot_d;
   logic [2:0]     ack_d;
   logic           oob_d;

   logic [2:0]     eligible;
   logic [2:0]     grant;
   logic           arb_en;
   logic [X_W-1:0] sel_x;
   logic [Y_W-1:0] sel_y;
   logic [C_W-1:0] sel_colour;
   logic           in_range;

   // A requester whose ack is still high is about to drop req, so it must not win again.
   assign eligible = {food_req & ~food_ack, tail_req & ~tail_ack, head_req & ~head_ack};
   assign arb_en   = (state_q == ST_IDLE) && !clear_req;
   assign busy     = (state_q == ST_CLEAR);

   rr_arbiter3 u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    (eligible),
      .en     (arb_en),
      .grant  (grant)
   );

   always_comb begin
      sel_x      = head_x;
      sel_y      = head_y;
      sel_colour = head_colour;
      if (grant[1]) begin
         sel_x      = tail_x;
         sel_y      = tail_y;
         sel_colour = BG_COLOUR;
      end else if (grant[2]) begin
         sel_x      = food_x;
         sel_y      = food_y;
         sel_colour = food_colour;
      end
   end

   assign in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);

   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      x_d      = vga_x;
      y_d      = vga_y;
      colour_d = vga_colour;
      plot_d   = 1'b0;
      ack_d    = 3'b000;
      oob_d    = oob_err;
      case (state_q)
         ST_CLEAR: begin
            x_d      = cx_q;
            y_d      = cy_q;
            colour_d = BG_COLOUR;
            plot_d   = 1'b1;
            if (cx_q == X_LAST) begin
               cx_d = '0;
               if (cy_q == Y_LAST) begin
                  cy_d    = '0;
                  state_d = ST_IDLE;
               end else begin
                  cy_d = cy_q + 1'b1;
               end
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         default: begin
            if (clear_req) begin
               cx_d    = '0;
               cy_d    = '0;
               state_d = ST_CLEAR;
            end else if (grant != 3'b000) begin
               // Off-screen writes still complete the handshake so the requester never stalls.
               ack_d    = grant;
               x_d      = sel_x;
               y_d      = sel_y;
               colour_d = sel_colour;
               plot_d   = in_range;
               if (!in_range) oob_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_CLEAR;
         cx_q       <= '0;
         cy_q       <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         head_ack   <= 1'b0;
         tail_ack   <= 1'b0;
         food_ack   <= 1'b0;
         oob_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         vga_x      <= x_d;
         vga_y      <= y_d;
         vga_colour <= colour_d;
         vga_plot   <= plot_d;
         head_ack   <= ack_d[0];
         tail_ack   <= ack_d[1];
         food_ack   <= ack_d[2];
         oob_err    <= oob_d;
      end
   end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter: frame clear, handshake, rotation, range check, resets.
module tb_plot_arbiter;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       clear_req = 1'b0;
   logic       busy, oob_err;
   logic       head_req = 1'b0, tail_req = 1'b0, food_req = 1'b0;
   logic [7:0] head_x = '0, tail_x = '0, food_x = '0;
   logic [6:0] head_y = '0, tail_y = '0, food_y = '0;
   logic [2:0] head_colour = '0, food_colour = '0;
   logic       head_ack, tail_ack, food_ack;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   plot_arbiter dut (
      .clk         (clk),
      .resetn      (resetn),
      .clear_req   (clear_req),
      .busy        (busy),
      .oob_err     (oob_err),
      .head_req    (head_req),
      .head_x      (head_x),
      .head_y      (head_y),
      .head_colour (head_colour),
      .head_ack    (head_ack),
      .tail_req    (tail_req),
      .tail_x      (tail_x),
      .tail_y      (tail_y),
      .tail_ack    (tail_ack),
      .food_req    (food_req),
      .food_x      (food_x),
      .food_y      (food_y),
      .food_colour (food_colour),
      .food_ack    (food_ack),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects the first clear pixel on the next edge; checks n_pix consecutive sweep writes.
   task automatic test_clear_sweep(input int n_pix, input string tag);
      int bad = 0;
      int first_bad = -1;
      logic [7:0] ex;
      logic [6:0] ey;
      for (int i = 0; i < n_pix; i++) begin
         tick();
         ex = 8'(i % 160);
         ey = 7'(i / 160);
         if (vga_plot !== 1'b1 || vga_x !== ex || vga_y !== ey || vga_colour !== 3'b000 ||
             {head_ack, tail_ack, food_ack} !== 3'b000 || busy !== (i != 19199)) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      checks++;
      if (bad !== 0) begin
         fails++;
         $display("[TB] FAIL %s sweep: %0d bad pixels, first at %0d (got x=%0d y=%0d c=%0d plot=%0b busy=%0b), required 0 bad",
                  tag, bad, first_bad, vga_x, vga_y, vga_colour, vga_plot, busy);
      end
   endtask

   task automatic test_reset();
      #2 resetn = 1'b0;
      #3;
      checks++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== 19'd0) begin
         fails++;
         $display("[TB] FAIL reset_vga: got %0h required 0", {vga_x, vga_y, vga_colour, vga_plot});
      end
      checks++;
      if ({head_ack, tail_ack, food_ack, oob_err} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_ack_oob: got %b required 0000", {head_ack, tail_ack, food_ack, oob_err});
      end
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_busy: got %b required 1", busy);
      end
      @(negedge clk);
      resetn = 1'b1;
      test_clear_sweep(19200, "power_on");
      tick();
      checks++;
      if (vga_plot !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL post_clear_idle: got plot=%b busy=%b required 0 0", vga_plot, busy);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] exp_ack [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      logic [7:0] exp_x   [6] = '{8'd30, 8'd50, 8'd70, 8'd30, 8'd50, 8'd70};
      logic [2:0] exp_c   [6] = '{3'b001, 3'b000, 3'b100, 3'b001, 3'b000, 3'b100};
      head_x = 8'd30; head_y = 7'd40; head_colour = 3'b001;
      tail_x = 8'd50; tail_y = 7'd60;
      food_x = 8'd70; food_y = 7'd80; food_colour = 3'b100;
      head_req = 1'b1; tail_req = 1'b1; food_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({food_ack, tail_ack, head_ack} !== exp_ack[i] || vga_x !== exp_x[i] ||
             vga_colour !== exp_c[i] || vga_plot !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rotation[%0d]: got ack=%b x=%0d c=%0d plot=%b required ack=%b x=%0d c=%0d plot=1",
                     i, {food_ack, tail_ack, head_ack}, vga_x, vga_colour, vga_plot, exp_ack[i], exp_x[i], exp_c[i]);
         end
      end
      head_req = 1'b0; tail_req = 1'b0; food_req = 1'b0;
      tick();
      checks++;
      if (vga_plot !== 1'b0 || {food_ack, tail_ack, head_ack} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL rotation_idle: got plot=%b ack=%b required 0 000", vga_plot, {food_ack, tail_ack, head_ack});
      end
   endtask

   task automatic test_single_head();
      head_x = 8'd10; head_y = 7'd20; head_colour = 3'b010;
      head_req = 1'b1;
      tick();
      checks++;
      if (head_ack !== 1'b1 || vga_plot !== 1'b1 || vga_x !== 8'd10 || vga_y !== 7'd20 || vga_colour !== 3'b010) begin
         fails++;
         $display("[TB] FAIL head_write: got ack=%b plot=%b x=%0d y=%0d c=%0d required 1 1 10 20 2",
                  head_ack, vga_plot, vga_x, vga_y, vga_colour);
      end
      tick();
      checks++;
      if (head_ack !== 1'b0 || vga_plot !== 1'b0 || vga_x !== 8'd10) begin
         fails++;
         $display("[TB] FAIL head_mask: got ack=%b plot=%b x=%0d required 0 0 10", head_ack, vga_plot, vga_x);
      end
      head_req = 1'b0;
      tick();
      head_x = 8'd159; head_y = 7'd119; head_colour = 3'b111;
      head_req = 1'b1;
      tick();
      checks++;
      if (head_ack !== 1'b1 || vga_plot !== 1'b1 || vga_x !== 8'd159 || vga_y !== 7'd119 || oob_err !== 1'b0) begin
         fails++;
         $display("[TB] FAIL head_corner: got ack=%b plot=%b x=%0d y=%0d oob=%b required 1 1 159 119 0",
                  head_ack, vga_plot, vga_x, vga_y, oob_err);
      end
      tick();
      head_req = 1'b0;
      tick();
   endtask

   task automatic test_oob();
      food_x = 8'd160; food_y = 7'd5; food_colour = 3'b100;
      food_req = 1'b1;
      tick();
      checks++;
      if (food_ack !== 1'b1 || vga_plot !== 1'b0 || oob_err !== 1'b1) begin
         fails++;
         $display("[TB] FAIL oob_write: got ack=%b plot=%b oob=%b required 1 0 1", food_ack, vga_plot, oob_err);
      end
      tick();
      food_req = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (oob_err !== 1'b1 || vga_plot !== 1'b0) begin
         fails++;
         $display("[TB] FAIL oob_sticky: got oob=%b plot=%b required 1 0", oob_err, vga_plot);
      end
   endtask

   task automatic test_clear_req();
      head_x = 8'd10; head_y = 7'd20; head_colour = 3'b010;
      head_req = 1'b1;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      checks++;
      if (head_ack !== 1'b0 || vga_plot !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL clear_precedence: got ack=%b plot=%b busy=%b required 0 0 1", head_ack, vga_plot, busy);
      end
      test_clear_sweep(19200, "clear_req");
      tick();
      checks++;
      if (head_ack !== 1'b1 || vga_plot !== 1'b1 || vga_x !== 8'd10 || vga_y !== 7'd20) begin
         fails++;
         $display("[TB] FAIL post_clear_grant: got ack=%b plot=%b x=%0d y=%0d required 1 1 10 20",
                  head_ack, vga_plot, vga_x, vga_y);
      end
      tick();
      head_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_clear();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 5000; i++) tick();
      checks++;
      if (vga_x !== 8'd39 || vga_y !== 7'd31 || busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL pixel_4999: got x=%0d y=%0d busy=%b required 39 31 1", vga_x, vga_y, busy);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({vga_x, vga_y, vga_colour, vga_plot} !== 19'd0 || oob_err !== 1'b0 || busy !== 1'b1 ||
          {head_ack, tail_ack, food_ack} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL mid_clear_reset: got vga=%0h oob=%b busy=%b ack=%b required 0 0 1 000",
                  {vga_x, vga_y, vga_colour, vga_plot}, oob_err, busy, {head_ack, tail_ack, food_ack});
      end
      @(negedge clk);
      resetn = 1'b1;
      test_clear_sweep(200, "restart");
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_single_head();
      test_oob();
      test_clear_req();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
